// File: rtl/ga_sync_irq.sv
// Gate-array sync/interrupt stage: shapes CRTC HSYNC/VSYNC for the monitor,
// runs the 52-line raster interrupt counter and latches the screen mode at HSYNC.
module ga_sync_irq #(
    parameter int INT_LINES = 52,
    parameter int MHS_DELAY = 2,
    parameter int MHS_WIDTH = 4,
    parameter int MVS_DELAY = 2,
    parameter int MVS_WIDTH = 4
) (
    input  logic       CLOCK,
    input  logic       nRESET,
    input  logic       CLKEN,
    input  logic       HSYNC_I,
    input  logic       VSYNC_I,
    input  logic       IRQ_ACK,
    input  logic       R52_CLR,
    input  logic       MODE_WR,
    input  logic [1:0] MODE_DI,
    output logic       HSYNC_O,
    output logic       VSYNC_O,
    output logic       INT,
    output logic [1:0] MODE,
    output logic [5:0] R52
);

    localparam logic [5:0] INT_LINES_C = 6'(INT_LINES);
    localparam logic [4:0] MHS_LO      = 5'(MHS_DELAY);
    localparam logic [4:0] MHS_HI      = 5'(MHS_DELAY + MHS_WIDTH);
    localparam logic [4:0] MVS_LO      = 5'(MVS_DELAY);
    localparam logic [4:0] MVS_HI      = 5'(MVS_DELAY + MVS_WIDTH);

    logic       hs_prev_q, hs_prev_d;
    logic       vs_prev_q, vs_prev_d;
    logic [3:0] hs_cnt_q, hs_cnt_d;
    logic [3:0] mvs_cnt_q, mvs_cnt_d;
    logic       vs_armed_q, vs_armed_d;
    logic [1:0] vs_cnt_q, vs_cnt_d;
    logic [5:0] r52_q, r52_d;
    logic       int_q, int_d;
    logic [1:0] mode_q, mode_d;
    logic [1:0] mode_pend_q, mode_pend_d;

    logic hs_rise, hs_fall, vs_rise;
    logic resync, wrap, set_int;

    assign hs_rise = CLKEN &  HSYNC_I & ~hs_prev_q;
    assign hs_fall = CLKEN & ~HSYNC_I &  hs_prev_q;
    assign vs_rise = CLKEN &  VSYNC_I & ~vs_prev_q;
    assign resync  = hs_fall & vs_armed_q & (vs_cnt_q == 2'd1);
    assign wrap    = hs_fall & ((r52_q + 6'd1) == INT_LINES_C);

    always_comb begin
        hs_prev_d   = CLKEN ? HSYNC_I : hs_prev_q;
        vs_prev_d   = CLKEN ? VSYNC_I : vs_prev_q;

        // Counting from the low level keeps the count at zero on the rise
        // sample, so no stale count from a short previous pulse can glitch.
        hs_cnt_d = hs_cnt_q;
        if (CLKEN) begin
            if (!HSYNC_I) begin
                hs_cnt_d = 4'd0;
            end else if (hs_cnt_q != 4'hF) begin
                hs_cnt_d = hs_cnt_q + 4'd1;
            end
        end

        mvs_cnt_d = mvs_cnt_q;
        if (CLKEN) begin
            if (!VSYNC_I || vs_rise) begin
                mvs_cnt_d = 4'd0;
            end else if (hs_fall && (mvs_cnt_q != 4'hF)) begin
                mvs_cnt_d = mvs_cnt_q + 4'd1;
            end
        end

        vs_armed_d = vs_armed_q;
        vs_cnt_d   = vs_cnt_q;
        if (vs_rise) begin
            vs_armed_d = 1'b1;
            vs_cnt_d   = 2'd0;
        end else if (resync) begin
            vs_armed_d = 1'b0;
        end else if (hs_fall && vs_armed_q) begin
            vs_cnt_d = vs_cnt_q + 2'd1;
        end

        set_int = 1'b0;
        r52_d   = r52_q;
        int_d   = int_q;
        if (R52_CLR) begin
            r52_d = 6'd0;
            int_d = 1'b0;
        end else begin
            if (resync) begin
                r52_d   = 6'd0;
                set_int = r52_q[5];
            end else if (wrap) begin
                r52_d   = 6'd0;
                set_int = 1'b1;
            end else if (hs_fall) begin
                r52_d = r52_q + 6'd1;
            end
            // A new interrupt in the same clock wins over the acknowledge.
            if (set_int) begin
                int_d = 1'b1;
            end else if (IRQ_ACK) begin
                int_d = 1'b0;
                r52_d = r52_d & 6'h1F;
            end
        end

        mode_pend_d = MODE_WR ? MODE_DI : mode_pend_q;
        mode_d      = hs_rise ? mode_pend_d : mode_q;
    end

    always_ff @(posedge CLOCK or negedge nRESET) begin
        if (!nRESET) begin
            hs_prev_q   <= 1'b0;
            vs_prev_q   <= 1'b0;
            hs_cnt_q    <= 4'd0;
            mvs_cnt_q   <= 4'd0;
            vs_armed_q  <= 1'b0;
            vs_cnt_q    <= 2'd0;
            r52_q       <= 6'd0;
            int_q       <= 1'b0;
            mode_q      <= 2'd0;
            mode_pend_q <= 2'd0;
        end else begin
            hs_prev_q   <= hs_prev_d;
            vs_prev_q   <= vs_prev_d;
            hs_cnt_q    <= hs_cnt_d;
            mvs_cnt_q   <= mvs_cnt_d;
            vs_armed_q  <= vs_armed_d;
            vs_cnt_q    <= vs_cnt_d;
            r52_q       <= r52_d;
            int_q       <= int_d;
            mode_q      <= mode_d;
            mode_pend_q <= mode_pend_d;
        end
    end

    assign HSYNC_O = HSYNC_I & ({1'b0, hs_cnt_q} >= MHS_LO) & ({1'b0, hs_cnt_q} < MHS_HI);
    assign VSYNC_O = VSYNC_I & ({1'b0, mvs_cnt_q} >= MVS_LO) & ({1'b0, mvs_cnt_q} < MVS_HI);
    assign INT     = int_q;
    assign MODE    = mode_q;
    assign R52     = r52_q;

endmodule

// File: doc/ga_sync_irq.md
# ga_sync_irq

Gate-array sync and interrupt stage, directly downstream of the CRTC in the Amstrad CPC video path. It consumes the CRTC's raw HSYNC/VSYNC and produces four things:
- the monitor-shaped HSYNC/VSYNC;
- the Z80 raster interrupt (the 52-line counter R52 with VSYNC resynchronisation);
- the screen mode latched at HSYNC start;
- the pixel serializer's mode input, taken from that latched mode.

All counting advances on the CRTC character-clock enable.

## Interface
Parameters:
- INT_LINES, 52: HSYNC falling edges per raster interrupt.
- MHS_DELAY, 2: character clocks from CRTC HSYNC rise to monitor HSYNC start.
- MHS_WIDTH, 4: maximum monitor HSYNC width in character clocks.
- MVS_DELAY, 2: HSYNC falling edges from CRTC VSYNC rise to monitor VSYNC start.
- MVS_WIDTH, 4: maximum monitor VSYNC width in HSYNC falling edges.

Ports:
- CLOCK, in, 1: system clock; the only clock.
- nRESET, in, 1: reset, asynchronous, active-low.
- CLKEN, in, 1: character-clock enable, the same enable the CRTC uses.
- HSYNC_I, in, 1: CRTC HSYNC.
- VSYNC_I, in, 1: CRTC VSYNC.
- IRQ_ACK, in, 1: Z80 interrupt-acknowledge, single CLOCK pulse.
- R52_CLR, in, 1: gate-array RMR write with DI[4]=1, single CLOCK pulse.
- MODE_WR, in, 1: gate-array RMR write strobe, single CLOCK pulse.
- MODE_DI, in, 2: requested mode (RMR DI[1:0]).
- HSYNC_O, out, 1: monitor HSYNC.
- VSYNC_O, out, 1: monitor VSYNC.
- INT, out, 1: Z80 interrupt request, level, active-high.
- MODE, out, 2: active screen mode.
- R52, out, 6: interrupt line counter (debug/status).

## Operation
- Edge detection is sampled on CLKEN only. `hs_prev` and `vs_prev` update on CLKEN cycles.
  - hs_rise = HSYNC_I & ~hs_prev
  - hs_fall = ~HSYNC_I & hs_prev
  - vs_rise = VSYNC_I & ~vs_prev
- R52 counter, 6 bits. Events are evaluated in this priority order, highest first:
  1. R52_CLR (any CLOCK): R52=0, INT=0.
  2. VSYNC resync (CLKEN & hs_fall while vs_armed and the resync count reaches 2): if R52[5]=1 then INT=1. R52=0 either way. vs_armed is cleared.
  3. Wrap (CLKEN & hs_fall and R52+1 == INT_LINES): R52=0, INT=1.
  4. Increment (CLKEN & hs_fall): R52=R52+1.
  5. IRQ_ACK (any CLOCK): INT=0, R52=R52 & 6'h1F. If event 2 or 3 sets INT in the same CLOCK, the ACK is discarded and INT stays 1.
- VSYNC resync arming:
  - vs_rise sets vs_armed=1 and vs_cnt=0.
  - Each subsequent hs_fall increments vs_cnt. The resync fires on the 2nd hs_fall.
  - A new vs_rise while armed restarts the arming.
- Monitor HSYNC:
  - hs_cnt (4 bits) clears on hs_rise, increments on CLKEN while HSYNC_I=1, and saturates at 15.
  - HSYNC_O = HSYNC_I & (hs_cnt >= MHS_DELAY) & (hs_cnt < MHS_DELAY+MHS_WIDTH).
  - A short CRTC HSYNC therefore truncates HSYNC_O or suppresses it entirely.
- Monitor VSYNC:
  - mvs_cnt (4 bits) clears on vs_rise and increments on hs_fall while VSYNC_I=1.
  - VSYNC_O = VSYNC_I & (mvs_cnt >= MVS_DELAY) & (mvs_cnt < MVS_DELAY+MVS_WIDTH).
- Mode:
  - MODE_WR loads mode_pend=MODE_DI on any CLOCK.
  - MODE <= mode_pend on CLKEN & hs_rise.
  - If MODE_WR and hs_rise occur in the same CLOCK, MODE takes the new MODE_DI.

## Timing
- Reset values (asynchronous, immediate): INT=0, R52=0, MODE=0, mode_pend=0, HSYNC_O=0, VSYNC_O=0, hs_prev=vs_prev=0, vs_armed=0, all counters 0.
- INT, R52, MODE and the internal counters are registered. INT rises on the CLOCK after the CLKEN edge that samples the qualifying hs_fall.
- HSYNC_O and VSYNC_O are combinational from registered counters and the live HSYNC_I/VSYNC_I. They drop in the same cycle the CRTC sync drops.
- IRQ_ACK and R52_CLR take effect on the next CLOCK edge, independent of CLKEN.
- Reset asserted mid-frame: all state clears at once. After release, the first hs_fall counts as R52=1. No spurious interrupt occurs, because hs_prev=0 blocks a fall on the first sample.
- Steady state with CRTC R0=63, R4=38, R9=7: INT pulses every 52 lines, 6 per frame. Each interrupt is held until IRQ_ACK.

## Test plan
- Free-run, no VSYNC, no ACK: 52 HSYNC pulses -> INT=1 after the 52nd fall, R52=0. The 53rd fall -> R52=1, INT still 1.
- INT pending at R52=40, then IRQ_ACK -> INT=0, R52=8. Counting continues and the next INT arrives after 44 more falls.
- VSYNC rise at R52=35 -> on the 2nd following hs_fall: R52=0, INT=1. Repeat with R52=20 -> R52=0, INT stays 0.
- CRTC HSYNC width 14 -> HSYNC_O high for character clocks 2..5 (4 clocks). Width 3 -> HSYNC_O high for 1 clock. Width 2 -> HSYNC_O never asserts.
- MODE_WR 2'b01 mid-line while MODE=0 -> MODE stays 0 until the next HSYNC_I rise, then becomes 1. MODE_WR coincident with hs_rise -> the new value applies on that rise.
- Simultaneous events:
  - R52_CLR on the same CLOCK as a wrap -> R52=0, INT=0.
  - IRQ_ACK on the same CLOCK as a wrap -> INT=1.
  - nRESET pulse mid-line -> all outputs 0 immediately.
